// File: rtl/fpu_pkg.sv
// Shared FPU definitions: result-slave FSM states and bus source tags.
package fpu_pkg;

   typedef enum logic [1:0] {
      SL_IDLE  = 2'd0,
      SL_ACK   = 2'd1,
      SL_STALL = 2'd2
   } slaveStateType;

   localparam logic SRC_ADDER = 1'b0;
   localparam logic SRC_MULT  = 1'b1;

endpackage

// File: rtl/fpu_sync_fifo.sv
// Synchronous FIFO with exact occupancy count; head is presented combinationally from storage.
module fpu_sync_fifo #(
   parameter  int unsigned W     = 33,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [W-1:0]     wdata,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [W-1:0]     rdata,
   output logic [CNT_W-1:0] count
);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

   // Pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      push_ok  = push && !full;
      pop_ok   = pop && !empty;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fpu_result_slave.sv
// Slave responder on the shared adder/multiplier request bus: captures results into a FIFO
// and acknowledges each capture with a one-cycle registered S_ack.
module fpu_result_slave
   import fpu_pkg::*;
#(
   parameter  int unsigned DATA_W = 32,
   parameter  int unsigned DEPTH  = 4,
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              S_req,
   input  logic              Select,
   output logic              S_ack,
   input  logic [DATA_W-1:0] M1_data,
   input  logic [DATA_W-1:0] M2_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_src,
   output logic [CNT_W-1:0]  count
);

   slaveStateType     state_q, state_d;
   logic              s_ack_q, s_ack_d;
   logic              push;
   logic [DATA_W:0]   wdata;
   logic [DATA_W:0]   rdata;
   logic              full;
   logic              empty;

   assign wdata = {Select, (Select == SRC_MULT) ? M2_data : M1_data};

   // Capture happens on the first edge with a request and room; the ack follows one cycle later.
   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      s_ack_d = 1'b0;
      case (state_q)
         SL_IDLE: begin
            if (S_req) begin
               if (!full) begin
                  push    = 1'b1;
                  state_d = SL_ACK;
               end else begin
                  state_d = SL_STALL;
               end
            end
         end
         SL_ACK: begin
            state_d = SL_IDLE;
         end
         SL_STALL: begin
            if (!S_req) begin
               state_d = SL_IDLE;
            end else if (!full) begin
               push    = 1'b1;
               state_d = SL_ACK;
            end
         end
         default: begin
            state_d = SL_IDLE;
         end
      endcase
      s_ack_d = push;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= SL_IDLE;
         s_ack_q <= 1'b0;
      end else begin
         state_q <= state_d;
         s_ack_q <= s_ack_d;
      end
   end

   fpu_sync_fifo #(
      .W     (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (push),
      .wdata (wdata),
      .pop   (out_ready),
      .full  (full),
      .empty (empty),
      .rdata (rdata),
      .count (count)
   );

   assign S_ack     = s_ack_q;
   assign out_valid = !empty;
   assign out_data  = rdata[DATA_W-1:0];
   assign out_src   = rdata[DATA_W];

endmodule

// File: tb/tb_fpu_result_slave.sv
// Self-checking bench for fpu_result_slave: directed scenarios plus randomized traffic
// compared every cycle against a queue-based transaction model.
module tb_fpu_result_slave;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

   logic              CLK;
   logic              RST;
   logic              S_req;
   logic              Select;
   logic              S_ack;
   logic [DATA_W-1:0] M1_data;
   logic [DATA_W-1:0] M2_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_src;
   logic [CNT_W-1:0]  count;

   int checks = 0;
   int errors = 0;

   // Model: entries held by the slave (src tag in MSB) and whether an ack is due now.
   logic [DATA_W:0] mq[$];
   bit              m_ack;

   fpu_result_slave #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .S_req     (S_req),
      .Select    (Select),
      .S_ack     (S_ack),
      .M1_data   (M1_data),
      .M2_data   (M2_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src),
      .count     (count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("s_ack", 64'(S_ack), 64'(m_ack));
      chk("count", 64'(count), 64'(mq.size()));
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("out_data", 64'(out_data), 64'(mq[0][DATA_W-1:0]));
         chk("out_src", 64'(out_src), 64'(mq[0][DATA_W]));
      end
   endtask

   // One clock: drive inputs, advance the model, check just after the edge.
   task automatic cycle(input logic req, input logic sel, input logic [DATA_W-1:0] d1,
                        input logic [DATA_W-1:0] d2, input logic rdy);
      bit was_full;
      bit cap;
      S_req     = req;
      Select    = sel;
      M1_data   = d1;
      M2_data   = d2;
      out_ready = rdy;
      was_full  = (mq.size() == DEPTH);
      cap       = req && !m_ack && !was_full;
      if (rdy && mq.size() != 0) void'(mq.pop_front());
      if (cap) mq.push_back({sel, sel ? d2 : d1});
      m_ack = cap;
      @(posedge CLK);
      #1;
      check_all();
   endtask

   // Hold a request until it is captured (bounded), then spend the ack cycle with S_req low.
   task automatic xfer(input logic sel, input logic [DATA_W-1:0] d, input logic rdy);
      int n;
      n = 0;
      do begin
         cycle(1'b1, sel, sel ? $urandom : d, sel ? d : $urandom, rdy);
         n++;
      end while (!m_ack && n < 20);
      if (!m_ack) chk("xfer_timeout", 64'(S_ack), 64'd1);
      cycle(1'b0, sel, $urandom, $urandom, rdy);
   endtask

   task automatic run_random(input int n, input bit toggle);
      bit              pend;
      logic            psel;
      logic [DATA_W-1:0] pdata;
      logic [DATA_W-1:0] d1;
      logic [DATA_W-1:0] d2;
      logic            rdy;
      pend = 1'b0;
      psel = 1'b0;
      pdata = '0;
      rdy = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (!pend && !m_ack && $urandom_range(0, 3) != 0) begin
            pend  = 1'b1;
            psel  = 1'($urandom_range(0, 1));
            pdata = $urandom;
         end
         if (pend && mq.size() == DEPTH && $urandom_range(0, 7) == 0) pend = 1'b0;
         rdy = toggle ? ~rdy : 1'($urandom_range(0, 2) != 0);
         d1 = $urandom;
         d2 = $urandom;
         if (pend) begin
            if (psel) d2 = pdata;
            else      d1 = pdata;
         end
         cycle(pend && !m_ack, pend ? psel : 1'($urandom_range(0, 1)), d1, d2, rdy);
         if (m_ack) pend = 1'b0;
      end
   endtask

   initial begin
      RST = 1'b1;
      S_req = 1'b0;
      Select = 1'b0;
      M1_data = '0;
      M2_data = '0;
      out_ready = 1'b0;
      m_ack = 1'b0;
      #1;
      chk("rst_s_ack", 64'(S_ack), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_src", 64'(out_src), 64'd0);
      @(posedge CLK);
      #1;
      RST = 1'b0;

      // Single adder result.
      cycle(1'b1, 1'b0, 32'h3F800000, 32'h12345678, 1'b0);
      chk("m1_ack", 64'(S_ack), 64'd1);
      chk("m1_data", 64'(out_data), 64'h3F800000);
      chk("m1_src", 64'(out_src), 64'd0);
      chk("m1_count", 64'(count), 64'd1);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("m1_ack_drop", 64'(S_ack), 64'd0);

      // Back-to-back adder then multiplier with downstream always ready.
      xfer(1'b0, 32'h40000000, 1'b1);
      xfer(1'b1, 32'h40400000, 1'b1);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      chk("b2b_empty", 64'(count), 64'd0);

      // Fill, stall a fifth request, then free one slot for a single cycle.
      for (int i = 0; i < 4; i++) xfer(1'(i % 2), $urandom, 1'b0);
      chk("full_count", 64'(count), 64'd4);
      repeat (3) cycle(1'b1, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0);
      chk("stall_no_ack", 64'(S_ack), 64'd0);
      cycle(1'b1, 1'b0, 32'hCAFEF00D, 32'h0, 1'b1);
      chk("pop_no_ack_yet", 64'(S_ack), 64'd0);
      chk("pop_count", 64'(count), 64'd3);
      cycle(1'b1, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0);
      chk("unstall_ack", 64'(S_ack), 64'd1);
      chk("refill_count", 64'(count), 64'd4);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

      // Withdraw while stalled.
      repeat (2) cycle(1'b1, 1'b1, 32'h0, 32'hDEADBEEF, 1'b0);
      repeat (2) cycle(1'b0, 1'b1, 32'h0, 32'hDEADBEEF, 1'b0);
      chk("withdraw_no_ack", 64'(S_ack), 64'd0);
      chk("withdraw_count", 64'(count), 64'd4);
      repeat (6) cycle(1'b0, 1'b0, $urandom, $urandom, 1'b1);

      // Asynchronous reset while an ack is showing and three entries are held.
      xfer(1'b0, 32'h11111111, 1'b0);
      xfer(1'b1, 32'h22222222, 1'b0);
      cycle(1'b1, 1'b0, 32'h33333333, 32'h0, 1'b0);
      chk("pre_rst_count", 64'(count), 64'd3);
      #2;
      RST = 1'b1;
      #1;
      chk("arst_s_ack", 64'(S_ack), 64'd0);
      chk("arst_count", 64'(count), 64'd0);
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      mq.delete();
      m_ack = 1'b0;
      S_req = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      check_all();

      // Ready toggling every cycle across pointer wrap, then general random traffic.
      run_random(60, 1'b1);
      run_random(500, 1'b0);
      repeat (8) cycle(1'b0, 1'b0, $urandom, $urandom, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
